// File: rtl/conv_out_quant_if.sv
// Stream bundle between the conv engine, the output quantizer and the downstream pixel sink.
interface conv_out_quant_if #(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 8
);
  logic signed [IN_WIDTH-1:0] result;
  logic                       resultValid;
  logic                       out_accepting_values;
  logic                       mode;
  logic [4:0]                 shift;
  logic [7:0]                 out_dim;
  logic [DATA_WIDTH-1:0]      pix_out;
  logic                       pix_valid;
  logic                       pix_ready;
  logic                       pix_last_col;
  logic                       frame_done;

  modport master (
    output result, resultValid, mode, shift, out_dim, pix_ready,
    input  out_accepting_values, pix_out, pix_valid, pix_last_col, frame_done
  );

  modport slave (
    input  result, resultValid, mode, shift, out_dim, pix_ready,
    output out_accepting_values, pix_out, pix_valid, pix_last_col, frame_done
  );
endinterface

// File: rtl/conv_out_quant.sv
// Conv result quantizer: abs/ReLU, arithmetic shift, saturation, output FIFO and row/col tracking.
// Optional macro CONV_OUT_ROUND_EN enables round-half-up before the shift.
module conv_out_quant #(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic             clock,
  input logic             reset,
  conv_out_quant_if.slave bus
);
  // One guard bit for |most-negative|, one for the rounding carry.
  localparam int unsigned MAG_W = IN_WIDTH + 2;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic                       s1_valid;
  logic signed [IN_WIDTH-1:0] s1_data;
  logic                       s2_valid;
  logic [DATA_WIDTH-1:0]      s2_data;
  logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [OCC_W-1:0]           occupancy;
  logic                       accept, push, pop;

  logic signed [MAG_W-1:0]    ext;
  logic [MAG_W-1:0]           mag, biased, shifted;
  logic [DATA_WIDTH-1:0]      quant;

  logic [7:0]                 col, row, col_nxt, row_nxt, last;
  logic                       frame_end;

  // Credit includes pipeline stages so nothing in flight can overflow the FIFO.
  assign occupancy = OCC_W'(count) + OCC_W'(s1_valid) + OCC_W'(s2_valid);
  assign bus.out_accepting_values = (occupancy < OCC_W'(FIFO_DEPTH));
  assign accept        = bus.resultValid && bus.out_accepting_values;
  assign push          = s2_valid;
  assign pop           = bus.pix_valid && bus.pix_ready;
  assign bus.pix_valid = (count != '0);
  assign bus.pix_out   = mem[rd_ptr];

  // S2 transform of the S1 result using the current mode/shift.
  always_comb begin
    ext     = MAG_W'(s1_data);
    mag     = '0;
    biased  = '0;
    shifted = '0;
    quant   = '0;
    if (!s1_data[IN_WIDTH-1]) begin
      mag = ext;
    end else if (!bus.mode) begin
      mag = -ext;
    end
    biased = mag;
`ifdef CONV_OUT_ROUND_EN
    if (bus.shift != 5'd0) begin
      biased = mag + (MAG_W'(1) << (bus.shift - 5'd1));
    end
`endif
    shifted = biased >> bus.shift;
    quant   = (shifted[MAG_W-1:DATA_WIDTH] != '0) ? '1 : DATA_WIDTH'(shifted);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_data <= bus.result;
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= quant;
    end
  end

  // Output FIFO; a push into an empty FIFO becomes visible only on the next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s2_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // out_dim of 0 wraps to 255 as the last index, i.e. 256 per row.
  always_comb begin
    last      = bus.out_dim - 8'd1;
    col_nxt   = col;
    row_nxt   = row;
    frame_end = 1'b0;
    if (pop) begin
      if (col == last) begin
        col_nxt = 8'd0;
        if (row == last) begin
          row_nxt   = 8'd0;
          frame_end = 1'b1;
        end else begin
          row_nxt = row + 8'd1;
        end
      end else begin
        col_nxt = col + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col              <= 8'd0;
      row              <= 8'd0;
      bus.pix_last_col <= 1'b0;
      bus.frame_done   <= 1'b0;
    end else begin
      col              <= col_nxt;
      row              <= row_nxt;
      bus.pix_last_col <= (col_nxt == last);
      bus.frame_done   <= frame_end;
    end
  end
endmodule

// File: tb/tb_conv_out_quant.sv
// Self-checking bench for conv_out_quant with an arithmetic reference model and a pixel scoreboard.
module tb_conv_out_quant;
  localparam int unsigned IN_WIDTH   = 32;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH = 8;
`ifdef CONV_OUT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  conv_out_quant_if #(.IN_WIDTH(IN_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();
  conv_out_quant #(.IN_WIDTH(IN_WIDTH), .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  function automatic int ref_pix(longint r, bit mode, int sh);
    longint m;
    longint maxv;
    maxv = (longint'(1) << DATA_WIDTH) - 1;
    if (r < 0) m = mode ? 0 : -r;
    else m = r;
    if (ROUND && sh > 0) m = m + (longint'(1) << (sh - 1));
    m = m / (longint'(1) << sh);
    return (m > maxv) ? int'(maxv) : int'(m);
  endfunction

  // Records an acceptance in the scoreboard, then advances to just after the next edge.
  task automatic tick();
    if (bus.resultValid && bus.out_accepting_values)
      exp_q.push_back(ref_pix(longint'(bus.result), bus.mode, int'(bus.shift)));
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    bus.resultValid = 1'b0;
    bus.pix_ready   = 1'b0;
    bus.result      = '0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    bus.resultValid = 1'b0; bus.pix_ready = 1'b1; bus.mode = 1'b0;
    bus.shift = 5'd0; bus.out_dim = 8'd1; bus.result = '0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %0b expected 0", bus.pix_valid); end
    checks++; if (bus.out_accepting_values !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", bus.out_accepting_values); end
    checks++; if (bus.pix_out !== '0) begin errors++; $display("FAIL reset_pix_out: got %0d expected 0", bus.pix_out); end
    checks++; if (bus.pix_last_col !== 1'b0) begin errors++; $display("FAIL reset_last_col: got %0b expected 0", bus.pix_last_col); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b expected 0", bus.frame_done); end
    reset = 1'b1;
  endtask

  task automatic test_abs();
    int exp3[3] = '{5, 255, 7};
    apply_reset();
    bus.mode = 1'b0; bus.shift = 5'd0; bus.out_dim = 8'd0; bus.pix_ready = 1'b1;
    bus.resultValid = 1'b1; bus.result = -32'sd5;
    tick();
    bus.result = 32'sd300;
    tick();
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL abs_latency_early: pix_valid %0b expected 0", bus.pix_valid); end
    bus.result = 32'sd7;
    tick();
    bus.resultValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.pix_valid !== 1'b1 || bus.pix_out !== DATA_WIDTH'(exp3[i])) begin
        errors++; $display("FAIL abs_pix%0d: valid %0b out %0d expected 1/%0d", i, bus.pix_valid, bus.pix_out, exp3[i]);
      end
      tick();
    end
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL abs_empty: pix_valid %0b expected 0", bus.pix_valid); end
  endtask

  task automatic test_relu();
    int res[3] = '{-40, 41, 42};
    int expc[3];
    int k = 0;
    expc[0] = 0; expc[1] = 10; expc[2] = ROUND ? 11 : 10;
    apply_reset();
    bus.mode = 1'b1; bus.shift = 5'd2; bus.out_dim = 8'd0; bus.pix_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.resultValid = 1'b1; bus.result = res[i];
      tick();
    end
    bus.resultValid = 1'b0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      if (bus.pix_valid && bus.pix_ready) begin
        checks++;
        if (bus.pix_out !== DATA_WIDTH'(expc[k])) begin
          errors++; $display("FAIL relu_pix%0d: got %0d expected %0d", k, bus.pix_out, expc[k]);
        end
        k++;
      end
      tick();
    end
    checks++; if (k != 3) begin errors++; $display("FAIL relu_count: got %0d pops expected 3", k); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int k = 0;
    int e;
    apply_reset();
    bus.mode = 1'b0; bus.shift = 5'($urandom_range(0, 3)); bus.out_dim = 8'd0;
    bus.pix_ready = 1'b0; bus.resultValid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.result = int'($urandom_range(0, 4000)) - 2000;
      if (bus.out_accepting_values) acc++;
      tick();
    end
    bus.resultValid = 1'b0;
    checks++; if (acc != int'(FIFO_DEPTH)) begin errors++; $display("FAIL bp_accepts: got %0d expected %0d", acc, FIFO_DEPTH); end
    checks++; if (bus.out_accepting_values !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %0b expected 0", bus.out_accepting_values); end
    checks++;
    if (bus.pix_valid !== 1'b1 || exp_q.size() == 0 || bus.pix_out !== DATA_WIDTH'(exp_q[0])) begin
      errors++; $display("FAIL bp_stall_head: valid %0b out %0d", bus.pix_valid, bus.pix_out);
    end
    bus.pix_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (bus.pix_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.pix_out !== DATA_WIDTH'(e)) begin
          errors++; $display("FAIL bp_drain%0d: got %0d expected %0d", k, bus.pix_out, e);
        end
        k++;
      end
      tick();
    end
    checks++; if (k != int'(FIFO_DEPTH)) begin errors++; $display("FAIL bp_drain_count: got %0d expected %0d", k, FIFO_DEPTH); end
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: pix_valid %0b expected 0", bus.pix_valid); end
  endtask

  task automatic test_frame();
    int sent = 0;
    int pops = 0;
    bit fd_exp = 1'b0;
    int e;
    apply_reset();
    bus.mode = 1'b0; bus.shift = 5'd0; bus.out_dim = 8'd3; bus.pix_ready = 1'b1;
    for (int c = 0; c < 60 && pops < 12; c++) begin
      checks++;
      if (bus.frame_done !== fd_exp) begin errors++; $display("FAIL frame_done_c%0d: got %0b expected %0b", c, bus.frame_done, fd_exp); end
      fd_exp = 1'b0;
      if (bus.pix_valid && bus.pix_ready) begin
        pops++;
        e = exp_q.pop_front();
        checks++;
        if (bus.pix_out !== DATA_WIDTH'(e)) begin errors++; $display("FAIL frame_pix%0d: got %0d expected %0d", pops, bus.pix_out, e); end
        checks++;
        if (bus.pix_last_col !== (pops % 3 == 0)) begin
          errors++; $display("FAIL frame_last_col%0d: got %0b expected %0b", pops, bus.pix_last_col, (pops % 3 == 0));
        end
        if (pops == 9) fd_exp = 1'b1;
      end
      bus.resultValid = (sent < 12);
      bus.result = sent + 1;
      if (bus.resultValid && bus.out_accepting_values) sent++;
      tick();
    end
    bus.resultValid = 1'b0;
    checks++; if (pops != 12) begin errors++; $display("FAIL frame_pops: got %0d expected 12", pops); end
    checks++; if (bus.frame_done !== fd_exp) begin errors++; $display("FAIL frame_done_end: got %0b expected %0b", bus.frame_done, fd_exp); end
  endtask

  task automatic test_reset_mid();
    int res[3] = '{50, 60, 70};
    int k = 0;
    apply_reset();
    bus.mode = 1'b0; bus.shift = 5'd0; bus.out_dim = 8'd3; bus.pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.resultValid = 1'b1; bus.result = 100 + i;
      tick();
    end
    bus.resultValid = 1'b0;
    repeat (3) tick();
    checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered: pix_valid %0b expected 1", bus.pix_valid); end
    reset = 1'b0;
    #2;
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL mid_in_reset_valid: got %0b expected 0", bus.pix_valid); end
    checks++; if (bus.out_accepting_values !== 1'b1) begin errors++; $display("FAIL mid_in_reset_ready: got %0b expected 1", bus.out_accepting_values); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    tick();
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid: got %0b expected 0", bus.pix_valid); end
    checks++; if (bus.out_accepting_values !== 1'b1) begin errors++; $display("FAIL mid_after_ready: got %0b expected 1", bus.out_accepting_values); end
    bus.pix_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.resultValid = 1'b1; bus.result = res[i];
      tick();
    end
    bus.resultValid = 1'b0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      if (bus.pix_valid) begin
        checks++;
        if (bus.pix_out !== DATA_WIDTH'(res[k]) || bus.pix_last_col !== (k == 2)) begin
          errors++; $display("FAIL mid_pix%0d: out %0d last %0b expected %0d/%0b", k, bus.pix_out, bus.pix_last_col, res[k], (k == 2));
        end
        k++;
      end
      tick();
    end
    checks++; if (k != 3) begin errors++; $display("FAIL mid_count: got %0d expected 3", k); end
  endtask

  task automatic test_min_neg();
    bit seen = 1'b0;
    apply_reset();
    bus.mode = 1'b0; bus.shift = 5'd24; bus.out_dim = 8'd0; bus.pix_ready = 1'b1;
    bus.resultValid = 1'b1; bus.result = 32'sh8000_0000;
    tick();
    bus.resultValid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus.pix_valid) begin
        seen = 1'b1;
        checks++;
        if (bus.pix_out !== DATA_WIDTH'(128)) begin errors++; $display("FAIL min_neg: got %0d expected 128", bus.pix_out); end
      end
      tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL min_neg_timeout: no pixel within 10 cycles"); end
  endtask

  task automatic test_random();
    for (int b = 0; b < 4; b++) begin
      int dim, mcol, mrow, e;
      bit fd_exp, hold_v;
      logic [DATA_WIDTH-1:0] hold_val;
      apply_reset();
      dim = int'($urandom_range(1, 5));
      bus.out_dim = 8'(dim);
      bus.mode = 1'($urandom_range(0, 1));
      bus.shift = 5'($urandom_range(0, 12));
      mcol = 0; mrow = 0; fd_exp = 1'b0; hold_v = 1'b0; hold_val = '0;
      for (int c = 0; c < 120; c++) begin
        if (c < 80) begin
          bus.resultValid = ($urandom_range(0, 9) < 7);
          case ($urandom_range(0, 3))
            0: bus.result = $urandom;
            1: bus.result = int'($urandom_range(0, 2000)) - 1000;
            2: bus.result = 32'sh8000_0000;
            default: bus.result = int'($urandom_range(0, 70000));
          endcase
          bus.pix_ready = ($urandom_range(0, 9) < 6);
        end else begin
          bus.resultValid = 1'b0;
          bus.pix_ready = 1'b1;
        end
        checks++;
        if (bus.frame_done !== fd_exp) begin errors++; $display("FAIL rnd_frame_done b%0d c%0d: got %0b expected %0b", b, c, bus.frame_done, fd_exp); end
        fd_exp = 1'b0;
        if (hold_v) begin
          checks++;
          if (bus.pix_valid !== 1'b1 || bus.pix_out !== hold_val) begin
            errors++; $display("FAIL rnd_hold b%0d c%0d: valid %0b out %0d expected 1/%0d", b, c, bus.pix_valid, bus.pix_out, hold_val);
          end
        end
        hold_v = bus.pix_valid && !bus.pix_ready;
        hold_val = bus.pix_out;
        if (bus.pix_valid && bus.pix_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          checks++;
          if (bus.pix_out !== DATA_WIDTH'(e) || e < 0) begin
            errors++; $display("FAIL rnd_pix b%0d c%0d: got %0d expected %0d", b, c, bus.pix_out, e);
          end
          checks++;
          if (bus.pix_last_col !== (mcol == dim - 1)) begin
            errors++; $display("FAIL rnd_last_col b%0d c%0d: got %0b expected %0b", b, c, bus.pix_last_col, (mcol == dim - 1));
          end
          if (mcol == dim - 1) begin
            mcol = 0;
            if (mrow == dim - 1) begin mrow = 0; fd_exp = 1'b1; end
            else mrow++;
          end else begin
            mcol++;
          end
        end
        tick();
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain b%0d: %0d pixels never appeared", b, exp_q.size()); end
    end
  endtask

  initial begin
    bus.result = '0; bus.resultValid = 1'b0; bus.mode = 1'b0; bus.shift = 5'd0;
    bus.out_dim = 8'd0; bus.pix_ready = 1'b0;
    test_reset();
    test_abs();
    test_relu();
    test_backpressure();
    test_frame();
    test_reset_mid();
    test_min_neg();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_out_quant.md
CONV_OUT_QUANT -- requirements
Module: conv_out_quant

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, width of the signed conv result.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of the output pixel.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, output buffer entries, power of two, at least 4.
REQ-004 SHALL have port clock, input, 1, sole clock; all state on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port result, input, IN_WIDTH, signed conv result.
REQ-007 SHALL have port resultValid, input, 1, result is valid this cycle.
REQ-008 SHALL have port out_accepting_values, output, 1, ready returned to conv.
REQ-009 SHALL have port mode, input, 1, 0 = absolute value, 1 = ReLU.
REQ-010 SHALL have port shift, input, 5, arithmetic right-shift amount.
REQ-011 SHALL have port out_dim, input, 8, output pixels per row and rows per frame.
REQ-012 SHALL have port pix_out, output, DATA_WIDTH, quantized pixel.
REQ-013 SHALL have port pix_valid, output, 1, pix_out is valid.
REQ-014 SHALL have port pix_ready, input, 1, downstream accepts pix_out.
REQ-015 SHALL have port pix_last_col, output, 1, pix_out is the last pixel of its row.
REQ-016 SHALL have port frame_done, output, 1, one-cycle pulse after the final pixel of a frame is popped.

Function
REQ-017 SHALL accept a result only in a cycle where resultValid and out_accepting_values are both high; at any other time result is ignored.
REQ-018 SHALL be a two-stage pipeline: S1 registers the accepted result; S2 transforms it and writes the FIFO.
REQ-019 SHALL transform as follows: mode 0 takes |result| and mode 1 takes max(result, 0), giving a magnitude m; then m >>> shift; then saturate to 2^DATA_WIDTH-1.
REQ-020 SHALL compute the magnitude at IN_WIDTH+1 bits so that |most-negative| does not overflow.
REQ-021 SHALL drive out_accepting_values = (fifo_count + S1/S2 occupancy) < FIFO_DEPTH, combinationally from registered state.
REQ-022 SHALL, for a result accepted at edge N into an empty FIFO, present it on pix_out with pix_valid high after edge N+2.
REQ-023 SHALL pop on pix_valid && pix_ready; pix_out and pix_valid SHALL hold stable while pix_valid && !pix_ready.
REQ-024 SHALL, on a simultaneous push and pop with a full FIFO, keep the count unchanged and lose no data; on a simultaneous push and pop with an empty FIFO, write only (no bypass).
REQ-025 SHALL advance the column counter per pop and wrap at out_dim-1, advancing the row counter on wrap.
REQ-026 SHALL assert pix_last_col when the column counter equals out_dim-1.
REQ-027 SHALL pulse frame_done one cycle after the pop at row = col = out_dim-1, then clear both counters.
REQ-028 SHALL treat out_dim = 0 as 256.
REQ-029 SHALL sample mode and shift in S2; changes to them take effect for the next transformed result.

Reset
REQ-030 SHALL, while reset is low, clear S1/S2 valid, the FIFO pointers and count, the row/col counters, pix_valid, pix_last_col, frame_done and pix_out to 0; out_accepting_values SHALL read 1.
REQ-031 SHALL, when reset is asserted mid-frame, discard all in-flight and buffered pixels; the first pop after release is column 0, row 0.

Configuration
REQ-032 SHALL support macro CONV_OUT_ROUND_EN: when defined, S2 adds 2^(shift-1) (only when shift > 0) to m before shifting (round-half-up); when undefined, the shift truncates.

Verification
REQ-033 SHALL cover: mode 0, shift 0, results -5, 300, 7 with pix_ready = 1 -> pix_out 5, 255, 7, the first appearing 2 cycles after acceptance.
REQ-034 SHALL cover: mode 1, shift 2, results -40, 41 -> 0, 10; with CONV_OUT_ROUND_EN defined -> 0, 10; result 42 -> 10 truncated, 11 rounded.
REQ-035 SHALL cover: pix_ready = 0 with continuous resultValid -> out_accepting_values falls after exactly FIFO_DEPTH acceptances; releasing pix_ready drains all 8 in order.
REQ-036 SHALL cover: out_dim = 3, 9 results -> pix_last_col on pops 3, 6 and 9; frame_done one cycle after pop 9; the counters restart at 0.
REQ-037 SHALL cover: reset pulse with 5 pixels buffered -> pix_valid 0 during and after reset; out_accepting_values 1; the next frame starts at column 0.
REQ-038 SHALL cover: result = -2^31, mode 0, shift 24 -> pix_out 128.
